// File: rtl/crossing_gate_sequencer_if.sv
// rtl/crossing_gate_sequencer_if.sv - sensor/motor/indicator bundle for the crossing gate sequencer
// Optional bell signal present when CROSSING_BELL_EN is defined.
interface crossing_gate_sequencer_if;
  logic trw;
  logic tre;
  logic gate_down_ack;
  logic gate_up_ack;
  logic gate_cmd_down;
  logic gate_cmd_up;
  logic light;
  logic busy;
  logic fault;
`ifdef CROSSING_BELL_EN
  logic bell;
`endif

  modport slave (
    input  trw, tre, gate_down_ack, gate_up_ack,
`ifdef CROSSING_BELL_EN
    output bell,
`endif
    output gate_cmd_down, gate_cmd_up, light, busy, fault
  );

  modport master (
    output trw, tre, gate_down_ack, gate_up_ack,
`ifdef CROSSING_BELL_EN
    input  bell,
`endif
    input  gate_cmd_down, gate_cmd_up, light, busy, fault
  );
endinterface

// File: rtl/crossing_gate_sequencer.sv
// rtl/crossing_gate_sequencer.sv - level-crossing gate/light sequencer driven by two track sensors
// Define CROSSING_BELL_EN to add the bell output (high in WARN and LOWER).
module crossing_gate_sequencer #(
  parameter int WARN_CYCLES    = 8,
  parameter int CLEAR_CYCLES   = 4,
  parameter int BLINK_DIV      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  crossing_gate_sequencer_if.slave bus
);

  localparam int WMAX = WARN_CYCLES - 1;
  localparam int CMAX = CLEAR_CYCLES - 1;
  localparam int TMAX = TIMEOUT_CYCLES - 1;
  localparam int M1   = (WMAX > CMAX) ? WMAX : CMAX;
  localparam int MAXV = (M1 > TMAX) ? M1 : TMAX;
  localparam int CW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);
  localparam int BW   = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);

  localparam logic [CW-1:0] WARN_LD  = CW'(WARN_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LD   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WARN  = 3'd1;
  localparam logic [2:0] LOWER = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] CLEAR = 3'd4;
  localparam logic [2:0] RAISE = 3'd5;
  localparam logic [2:0] FAULT = 3'd6;

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic          entry_w, entry_nx;
  logic          seen_exit, seen_nx;
  logic          light, light_nx;
  logic          any_sensor, opp_sensor;

  assign any_sensor = bus.trw | bus.tre;
  // The exit sensor is the one opposite to the side the train entered from.
  assign opp_sensor = entry_w ? bus.tre : bus.trw;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    entry_nx = entry_w;
    seen_nx  = seen_exit;
    if ((state == WARN || state == LOWER || state == HOLD) && opp_sensor)
      seen_nx = 1'b1;

    case (state)
      IDLE: begin
        if (any_sensor) begin
          state_nx = WARN;
          cnt_nx   = WARN_LD;
          entry_nx = bus.trw;
          seen_nx  = 1'b0;
        end
      end
      WARN: begin
        if (cnt == '0) begin
          state_nx = LOWER;
          cnt_nx   = TMO_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      LOWER: begin
        if (bus.gate_down_ack) begin
          state_nx = HOLD;
        end else if (cnt == '0) begin
          state_nx = FAULT;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (seen_exit && !any_sensor) begin
          state_nx = CLEAR;
          cnt_nx   = CLEAR_LD;
        end
      end
      CLEAR: begin
        if (any_sensor) begin
          state_nx = HOLD;
          entry_nx = bus.trw;
          seen_nx  = 1'b0;
        end else if (cnt == '0) begin
          state_nx = RAISE;
          cnt_nx   = TMO_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      RAISE: begin
        // A new train beats the up-ack: the gate goes straight back down.
        if (any_sensor) begin
          state_nx = LOWER;
          cnt_nx   = TMO_LD;
          entry_nx = bus.trw;
          seen_nx  = 1'b0;
        end else if (bus.gate_up_ack) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = FAULT;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      FAULT: state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    light_nx = light;
    bcnt_nx  = bcnt;
    case (state)
      IDLE: begin
        if (state_nx == WARN) begin
          light_nx = 1'b1;
          bcnt_nx  = BLINK_LD;
        end else begin
          light_nx = 1'b0;
        end
      end
      FAULT: light_nx = 1'b1;
      default: begin
        if (state_nx == IDLE) begin
          light_nx = 1'b0;
        end else if (state_nx == FAULT) begin
          light_nx = 1'b1;
        end else if (bcnt == '0) begin
          light_nx = ~light;
          bcnt_nx  = BLINK_LD;
        end else begin
          bcnt_nx = bcnt - BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      entry_w   <= 1'b0;
      seen_exit <= 1'b0;
      light     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bcnt      <= bcnt_nx;
      entry_w   <= entry_nx;
      seen_exit <= seen_nx;
      light     <= light_nx;
    end
  end

  assign bus.gate_cmd_down = (state == LOWER);
  assign bus.gate_cmd_up   = (state == RAISE);
  assign bus.busy          = (state != IDLE);
  assign bus.fault         = (state == FAULT);
  assign bus.light         = light;
`ifdef CROSSING_BELL_EN
  assign bus.bell          = (state == WARN) || (state == LOWER);
`endif

endmodule

// File: tb/tb_crossing_gate_sequencer.sv
// tb/tb_crossing_gate_sequencer.sv - directed self-checking bench for crossing_gate_sequencer
// Checks bell as well when CROSSING_BELL_EN is defined.
module tb_crossing_gate_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_WARN  = 1;
  localparam int S_LOWER = 2;
  localparam int S_HOLD  = 3;
  localparam int S_CLEAR = 4;
  localparam int S_RAISE = 5;
  localparam int S_FAULT = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   since  = -1;

  always #5 clk = ~clk;

  crossing_gate_sequencer_if bus ();

  crossing_gate_sequencer #(
    .WARN_CYCLES(8), .CLEAR_CYCLES(4), .BLINK_DIV(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // {busy, fault, gate_cmd_down, gate_cmd_up, light}; light has period 4 from WARN entry
  function automatic logic [4:0] exp_vec(input int s, input int sn);
    logic l;
    if (s == S_IDLE)       l = 1'b0;
    else if (s == S_FAULT) l = 1'b1;
    else                   l = ((sn / 2) % 2) == 0;
    return {s != S_IDLE, s == S_FAULT, s == S_LOWER, s == S_RAISE, l};
  endfunction

  task automatic check_state(input string tag, input int s);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {bus.busy, bus.fault, bus.gate_cmd_down, bus.gate_cmd_up, bus.light};
    exp = exp_vec(s, since);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (busy,fault,dn,up,light)", tag, obs, exp);
    end
`ifdef CROSSING_BELL_EN
    checks++;
    assert (bus.bell === ((s == S_WARN) || (s == S_LOWER))) else begin
      errors++;
      $error("FAIL %s_bell: observed %b expected %b", tag, bus.bell, (s == S_WARN) || (s == S_LOWER));
    end
`endif
  endtask

  task automatic cyc(input logic w, input logic e, input logic da, input logic ua,
                     input int s, input string tag);
    bus.trw = w;
    bus.tre = e;
    bus.gate_down_ack = da;
    bus.gate_up_ack = ua;
    @(posedge clk);
    #1;
    if (s == S_IDLE) since = -1;
    else since++;
    check_state(tag, s);
  endtask

  task automatic rep(input int n, input logic w, input logic e, input logic da, input logic ua,
                     input int s, input string tag);
    for (int i = 0; i < n; i++) cyc(w, e, da, ua, s, tag);
  endtask

  task automatic async_reset(input string tag);
    bus.trw = 1'b0;
    bus.tre = 1'b0;
    bus.gate_down_ack = 1'b0;
    bus.gate_up_ack = 1'b0;
    reset = 1'b1;
    #2;
    since = -1;
    check_state({tag, "_during"}, S_IDLE);
    @(posedge clk);
    #1;
    check_state({tag, "_held"}, S_IDLE);
    reset = 1'b0;
    cyc(0, 0, 0, 0, S_IDLE, {tag, "_released"});
  endtask

  initial begin
    bus.trw = 1'b0;
    bus.tre = 1'b0;
    bus.gate_down_ack = 1'b0;
    bus.gate_up_ack = 1'b0;
    reset = 1'b1;
    #1;
    check_state("reset", S_IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // West train, acks three cycles after each command
    rep(2, 0, 0, 0, 0, S_IDLE,  "t1_idle");
    cyc(1, 0, 0, 0, S_WARN,     "t1_warn_entry");
    rep(3, 1, 0, 0, 0, S_WARN,  "t1_warn_trw");
    rep(4, 0, 0, 0, 0, S_WARN,  "t1_warn");
    rep(2, 0, 0, 0, 0, S_LOWER, "t1_lower");
    cyc(0, 1, 0, 0, S_LOWER,    "t1_lower_tre");
    cyc(0, 1, 1, 0, S_HOLD,     "t1_hold_entry");
    rep(2, 0, 1, 1, 0, S_HOLD,  "t1_hold");
    cyc(0, 0, 1, 0, S_CLEAR,    "t1_clear_entry");
    rep(3, 0, 0, 1, 0, S_CLEAR, "t1_clear");
    cyc(0, 0, 1, 0, S_RAISE,    "t1_raise_entry");
    rep(2, 0, 0, 0, 0, S_RAISE, "t1_raise");
    cyc(0, 0, 0, 1, S_IDLE,     "t1_idle_return");
    cyc(0, 0, 0, 0, S_IDLE,     "t1_idle_after");

    // Retrigger during CLEAR, exit then expected on trw
    cyc(1, 0, 0, 0, S_WARN,     "t2_warn_entry");
    rep(7, 0, 0, 0, 0, S_WARN,  "t2_warn");
    cyc(0, 0, 0, 0, S_LOWER,    "t2_lower");
    cyc(0, 1, 1, 0, S_HOLD,     "t2_hold");
    rep(2, 0, 0, 1, 0, S_CLEAR, "t2_clear");
    cyc(0, 1, 1, 0, S_HOLD,     "t2_retrigger");
    rep(6, 0, 0, 1, 0, S_HOLD,  "t2_hold_no_exit");
    cyc(1, 0, 1, 0, S_HOLD,     "t2_hold_trw_exit");
    cyc(0, 0, 1, 0, S_CLEAR,    "t2_clear2_entry");
    rep(3, 0, 0, 1, 0, S_CLEAR, "t2_clear2");
    cyc(0, 0, 1, 0, S_RAISE,    "t2_raise");

    // Sensor on the first RAISE cycle sends the gate back down
    cyc(1, 0, 0, 0, S_LOWER,    "t3_raise_to_lower");
    cyc(0, 1, 0, 1, S_LOWER,    "t3_lower_ignores_upack");
    cyc(0, 0, 1, 0, S_HOLD,     "t3_hold");
    cyc(0, 0, 1, 0, S_CLEAR,    "t3_clear_entry");
    rep(3, 0, 0, 1, 0, S_CLEAR, "t3_clear");
    cyc(0, 0, 1, 0, S_RAISE,    "t3_raise");
    cyc(0, 0, 1, 1, S_IDLE,     "t3_idle");

    // Train backs out west without reaching the east sensor
    cyc(1, 0, 0, 0, S_WARN,     "t5_warn_entry");
    rep(7, 1, 0, 0, 0, S_WARN,  "t5_warn");
    cyc(1, 0, 0, 0, S_LOWER,    "t5_lower");
    cyc(1, 0, 1, 0, S_HOLD,     "t5_hold_entry");
    rep(3, 1, 0, 1, 0, S_HOLD,  "t5_hold_trw");
    rep(20, 0, 0, 1, 0, S_HOLD, "t5_hold_reversed");

    // Asynchronous reset mid-HOLD, restart, then reset mid-WARN
    async_reset("t6_rst_hold");
    cyc(0, 1, 0, 0, S_WARN,     "t6_restart_warn");
    rep(3, 0, 0, 0, 0, S_WARN,  "t6_warn");
    async_reset("t6_rst_warn");
    cyc(1, 0, 0, 0, S_WARN,     "t6_restart2_warn");
    rep(7, 0, 0, 0, 0, S_WARN,  "t6_warn2");
    cyc(0, 0, 0, 0, S_LOWER,    "t6_lower");
    cyc(0, 0, 1, 1, S_HOLD,     "t6_hold");

    // Motor never acks the down command
    async_reset("t4_pre");
    cyc(1, 0, 0, 0, S_WARN,     "t4_warn_entry");
    rep(7, 0, 0, 0, 0, S_WARN,  "t4_warn");
    rep(16, 0, 0, 0, 1, S_LOWER, "t4_lower_wait");
    cyc(0, 0, 0, 0, S_FAULT,    "t4_fault_entry");
    for (int i = 0; i < 50; i++) begin
      logic [3:0] v;
      v = 4'(i);
      cyc(v[0], v[1], v[2], v[3], S_FAULT, "t4_fault_sticky");
    end
    async_reset("t4_rst_fault");
    cyc(0, 1, 0, 0, S_WARN,     "t4_restart_warn");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
